// File: rtl/bank_burst_sequencer.sv
// Request-side sequencer for an 8-bank byte memory: holds bank port timing for
// byte writes and steps the output mux to assemble 8-byte line reads.
module bank_burst_sequencer #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned WR_LATENCY = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ_VALID,
    output logic                REQ_READY,
    input  logic                REQ_WE,
    input  logic [ADDR_W-1:0]   REQ_ADDR,
    input  logic [DATA_W-1:0]   REQ_DATA,
    output logic                WR_ACK,
    output logic                LINE_VALID,
    input  logic                LINE_READY,
    output logic [8*DATA_W-1:0] LINE_DATA,
    output logic                MEM_EN,
    output logic                MEM_WE,
    output logic [ADDR_W-1:0]   MEM_ADDR,
    output logic [DATA_W-1:0]   MEM_DI,
    output logic [2:0]          MEM_SELECT,
    input  logic [DATA_W-1:0]   MEM_DO
);

    localparam int unsigned HOLD_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HOLD_W-1:0] WR_LAST = HOLD_W'(WR_LATENCY - 1);
    localparam logic [HOLD_W-1:0] RD_LAST = HOLD_W'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrHold,
        StWrAck,
        StRdHold,
        StRdCapture,
        StLineOut
    } state_e;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q;
    logic [2:0]          k_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [8*DATA_W-1:0] line_q;
    logic                accept;
    logic                in_hold;
    logic [ADDR_W-1:0]   line_addr;

    assign accept    = (state_q == StIdle) && REQ_VALID;
    assign in_hold   = (state_q == StWrHold) || (state_q == StRdHold);
    // Line reads always start at bank 0 of the addressed row.
    assign line_addr = {addr_q[ADDR_W-1:3], 3'b000};
    assign LINE_DATA = line_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (REQ_VALID) state_d = REQ_WE ? StWrHold : StRdHold;
            StWrHold:    if (hold_q == WR_LAST) state_d = StWrAck;
            StWrAck:     state_d = StIdle;
            StRdHold:    if (hold_q == RD_LAST) state_d = StRdCapture;
            StRdCapture: if (k_q == 3'd7) state_d = StLineOut;
            StLineOut:   if (LINE_READY) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_q <= '0;
            k_q    <= 3'd0;
            addr_q <= '0;
            data_q <= '0;
            line_q <= '0;
        end else begin
            hold_q <= (in_hold && (state_d == state_q)) ? hold_q + 1'b1 : '0;
            // k wraps from 7 back to 0 on the way out of capture.
            k_q    <= (state_q == StRdCapture) ? k_q + 3'd1 : 3'd0;
            if (accept) begin
                addr_q <= REQ_ADDR;
                data_q <= REQ_DATA;
            end
            if (state_q == StRdCapture) begin
                line_q[k_q*DATA_W +: DATA_W] <= MEM_DO;
            end
        end
    end

    always_comb begin
        REQ_READY  = 1'b0;
        WR_ACK     = 1'b0;
        LINE_VALID = 1'b0;
        MEM_EN     = 1'b0;
        MEM_WE     = 1'b0;
        MEM_ADDR   = '0;
        MEM_DI     = '0;
        MEM_SELECT = 3'd0;
        unique case (state_q)
            StIdle:   REQ_READY = 1'b1;
            StWrHold: begin
                MEM_EN   = 1'b1;
                MEM_WE   = 1'b1;
                MEM_ADDR = addr_q;
                MEM_DI   = data_q;
            end
            StWrAck:  WR_ACK = 1'b1;
            StRdHold: begin
                MEM_EN   = 1'b1;
                MEM_ADDR = line_addr;
            end
            StRdCapture: begin
                MEM_EN     = 1'b1;
                MEM_ADDR   = line_addr;
                MEM_SELECT = k_q;
            end
            StLineOut: LINE_VALID = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_bank_burst_sequencer.sv
// Bench for bank_burst_sequencer: bank memory model, timeline reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_bank_burst_sequencer;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned WR_LAT = 2;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              REQ_VALID = 1'b0;
    logic              REQ_READY;
    logic              REQ_WE = 1'b0;
    logic [ADDR_W-1:0] REQ_ADDR = '0;
    logic [7:0]        REQ_DATA = '0;
    logic              WR_ACK;
    logic              LINE_VALID;
    logic              LINE_READY = 1'b0;
    logic [63:0]       LINE_DATA;
    logic              MEM_EN;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [7:0]        MEM_DI;
    logic [2:0]        MEM_SELECT;
    logic [7:0]        MEM_DO;

    bank_burst_sequencer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_LATENCY(RD_LAT),
        .WR_LATENCY(WR_LAT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WE    (REQ_WE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_DATA  (REQ_DATA),
        .WR_ACK    (WR_ACK),
        .LINE_VALID(LINE_VALID),
        .LINE_READY(LINE_READY),
        .LINE_DATA (LINE_DATA),
        .MEM_EN    (MEM_EN),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_DI    (MEM_DI),
        .MEM_SELECT(MEM_SELECT),
        .MEM_DO    (MEM_DO)
    );

    always #5 CLK = ~CLK;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bank memory: address registered, then row registered, then muxed by SELECT.
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [7:0]        pl_data = '0;
    logic [7:0]        bank_mem [0:DEPTH-1];
    logic [ADDR_W-1:0] bk_addr;
    logic [63:0]       bk_row;

    always @(posedge CLK) begin
        if (pl_en) bank_mem[pl_addr] <= pl_data;
        if (MEM_EN && MEM_WE) bank_mem[MEM_ADDR] <= MEM_DI;
        if (MEM_EN) bk_addr <= MEM_ADDR;
        for (int i = 0; i < 8; i++) begin
            bk_row[8*i +: 8] <= bank_mem[{bk_addr[ADDR_W-1:3], 3'(i)}];
        end
    end

    assign MEM_DO = MEM_WE ? 8'h00 : bk_row[8*MEM_SELECT +: 8];

    // Reference model: a transaction timeline indexed by cycles since acceptance.
    localparam int KIdle = 0;
    localparam int KWr   = 1;
    localparam int KRd   = 2;

    int                m_kind = KIdle;
    int                m_d    = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [7:0]        m_data = '0;
    logic [63:0]       exp_line = '0;
    logic [7:0]        shadow [0:DEPTH-1];

    always @(negedge CLK) begin : model
        logic              e_ready, e_ack, e_lv, e_en, e_we, chk_line;
        logic [ADDR_W-1:0] e_addr, row_base;
        logic [7:0]        e_di;
        logic [2:0]        e_sel;
        e_ready  = 1'b0;
        e_ack    = 1'b0;
        e_lv     = 1'b0;
        e_en     = 1'b0;
        e_we     = 1'b0;
        e_addr   = '0;
        e_di     = '0;
        e_sel    = 3'd0;
        chk_line = 1'b1;
        row_base = {m_addr[ADDR_W-1:3], 3'b000};
        if (RST) begin
            m_kind   = KIdle;
            m_d      = 0;
            exp_line = '0;
            e_ready  = 1'b1;
        end else if (m_kind == KIdle) begin
            e_ready = 1'b1;
        end else if (m_kind == KWr) begin
            if (m_d <= int'(WR_LAT)) begin
                e_en   = 1'b1;
                e_we   = 1'b1;
                e_addr = m_addr;
                e_di   = m_data;
            end else begin
                e_ack = 1'b1;
            end
        end else begin
            if (m_d <= int'(RD_LAT) + 8) begin
                e_en   = 1'b1;
                e_addr = row_base;
                if (m_d > int'(RD_LAT)) e_sel = 3'(m_d - int'(RD_LAT) - 1);
                if (m_d > int'(RD_LAT) + 1) chk_line = 1'b0;
            end else begin
                e_lv = 1'b1;
            end
        end
        check("req_ready", 64'(REQ_READY), 64'(e_ready));
        check("wr_ack", 64'(WR_ACK), 64'(e_ack));
        check("line_valid", 64'(LINE_VALID), 64'(e_lv));
        check("mem_en", 64'(MEM_EN), 64'(e_en));
        check("mem_we", 64'(MEM_WE), 64'(e_we));
        check("mem_addr", 64'(MEM_ADDR), 64'(e_addr));
        check("mem_di", 64'(MEM_DI), 64'(e_di));
        check("mem_select", 64'(MEM_SELECT), 64'(e_sel));
        if (chk_line) check("line_data", LINE_DATA, exp_line);

        if (!RST) begin
            if (pl_en) shadow[pl_addr] = pl_data;
            if (m_kind == KIdle) begin
                if (REQ_VALID) begin
                    m_kind = REQ_WE ? KWr : KRd;
                    m_addr = REQ_ADDR;
                    m_data = REQ_DATA;
                    m_d    = 1;
                    if (REQ_WE) shadow[REQ_ADDR] = REQ_DATA;
                end
            end else if (m_kind == KWr) begin
                if (m_d == int'(WR_LAT) + 1) m_kind = KIdle;
                else m_d = m_d + 1;
            end else begin
                if (m_d < int'(RD_LAT) + 9) begin
                    m_d = m_d + 1;
                    if (m_d == int'(RD_LAT) + 9) begin
                        for (int i = 0; i < 8; i++) begin
                            exp_line[8*i +: 8] = shadow[row_base + ADDR_W'(i)];
                        end
                    end
                end else if (LINE_READY) begin
                    m_kind = KIdle;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                        output int unsigned acc);
        logic got;
        got = 1'b0;
        acc = 0;
        tick();
        REQ_WE    = we;
        REQ_ADDR  = a;
        REQ_DATA  = d;
        REQ_VALID = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK);
            if (REQ_READY) begin
                got = 1'b1;
                acc = cyc;
                break;
            end
        end
        check("accept_seen", 64'(got), 64'd1);
        tick();
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_line(input string name, output int unsigned lvc, output int unsigned we_cnt);
        logic got;
        got    = 1'b0;
        lvc    = 0;
        we_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK);
            if (MEM_WE) we_cnt++;
            if (LINE_VALID) begin
                got = 1'b1;
                lvc = cyc;
                break;
            end
        end
        check(name, 64'(got), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc, lvc, wec, ack_cyc, seen;
        logic        got;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", 64'(REQ_READY), 64'd1);
        check("rst_mem_en", 64'(MEM_EN), 64'd0);
        check("rst_line", LINE_DATA, 64'd0);
        RST = 1'b0;

        // Preload row 0 with 00..07 and row 3 with 10..17
        for (int i = 0; i < 8; i++) begin
            pl_en   = 1'b1;
            pl_addr = ADDR_W'(i);
            pl_data = 8'(i);
            tick();
            pl_addr = 14'h0018 + ADDR_W'(i);
            pl_data = 8'h10 + 8'(i);
            tick();
        end
        pl_en = 1'b0;

        // Reset in the middle of a capture
        send(1'b0, 14'h0018, 8'h00, acc);
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (MEM_SELECT == 3'd4) begin
                got = 1'b1;
                break;
            end
        end
        check("t1_reach_k4", 64'(got), 64'd1);
        #1 RST = 1'b1;
        #1;
        check("t1_async_outs", 64'({MEM_EN, MEM_WE, MEM_SELECT, LINE_VALID, WR_ACK}), 64'd0);
        check("t1_async_ready", 64'(REQ_READY), 64'd1);
        check("t1_async_line", LINE_DATA, 64'd0);
        @(posedge CLK);
        tick();
        RST  = 1'b0;
        seen = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge CLK);
            if (LINE_VALID) seen++;
        end
        check("t1_no_line", 64'(seen), 64'd0);

        // Single byte write
        send(1'b1, 14'h0005, 8'hA5, acc);
        for (int d = 1; d <= 2; d++) begin
            @(negedge CLK);
            check("t2_hold", {40'd0, MEM_EN, MEM_WE, MEM_ADDR, MEM_DI}, {40'd0, 2'b11, 14'h0005, 8'hA5});
        end
        @(negedge CLK);
        check("t2_ack", 64'({WR_ACK, MEM_EN, MEM_WE}), 64'b100);
        @(negedge CLK);
        check("t2_ready_back", 64'({REQ_READY, WR_ACK}), 64'b10);

        // Line read of row 3 with an unaligned address
        send(1'b0, 14'h001D, 8'h00, acc);
        wait_line("t3_line_seen", lvc, wec);
        check("t3_latency", 64'(lvc - acc), 64'd11);
        check("t3_line", LINE_DATA, 64'h1716151413121110);
        #1;
        check("model_line_row3", exp_line, 64'h1716151413121110);

        // Consumer stalls while a new request is offered
        for (int i = 0; i < 5; i++) begin
            tick();
            REQ_VALID = 1'b1;
            REQ_WE    = 1'b1;
            REQ_ADDR  = 14'h0000;
            @(negedge CLK);
            check("t4_stall", {LINE_VALID, REQ_READY, LINE_DATA[61:0]},
                  {2'b10, 62'h1716151413121110});
        end
        tick();
        LINE_READY = 1'b1;
        REQ_VALID  = 1'b0;
        @(negedge CLK);
        check("t4_taken_cycle", 64'(LINE_VALID), 64'd1);
        tick();
        LINE_READY = 1'b0;
        @(negedge CLK);
        check("t4_after_take", 64'({LINE_VALID, REQ_READY}), 64'b01);

        // Write then read back-to-back with REQ_VALID held
        tick();
        REQ_WE    = 1'b1;
        REQ_ADDR  = 14'h0019;
        REQ_DATA  = 8'h5A;
        REQ_VALID = 1'b1;
        @(negedge CLK);
        check("t5_wr_accept", 64'(REQ_READY), 64'd1);
        tick();
        REQ_WE   = 1'b0;
        REQ_ADDR = 14'h0018;
        got      = 1'b0;
        ack_cyc  = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge CLK);
            if (WR_ACK) begin
                got     = 1'b1;
                ack_cyc = cyc;
                break;
            end
        end
        check("t5_ack_seen", 64'(got), 64'd1);
        @(negedge CLK);
        check("t5_rd_accept_next", 64'({REQ_READY, 32'(cyc - ack_cyc)}), {31'd0, 1'b1, 32'd1});
        acc = cyc;
        tick();
        REQ_VALID = 1'b0;
        wait_line("t5_line_seen", lvc, wec);
        check("t5_no_we", 64'(wec), 64'd0);
        check("t5_latency", 64'(lvc - acc), 64'd11);
        check("t5_line", LINE_DATA, 64'h1716151413125A10);
        tick();
        LINE_READY = 1'b1;
        tick();
        LINE_READY = 1'b0;

        // Consumer always ready: one-cycle LINE_VALID
        tick();
        LINE_READY = 1'b1;
        send(1'b0, 14'h0003, 8'h00, acc);
        wait_line("t6_line_seen", lvc, wec);
        check("t6_latency", 64'(lvc - acc), 64'd11);
        check("t6_line", LINE_DATA, 64'h0706A50403020100);
        @(negedge CLK);
        check("t6_pulse", 64'({LINE_VALID, REQ_READY}), 64'b01);
        tick();
        LINE_READY = 1'b0;

        repeat (3) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
